fsm16bit_decoder: RTL and testbench

Receive-side counterpart of `fsm16bit`. It watches the 16-bit output stream of a `fsm16bit` instance and, for each new sample, recovers which control settings produced it. The recovered settings are `mode`, `direction` and the 4-bit `value`, or a hold. It flags any transition the FSM cannot produce. It sits beside `fsm16bit` as a checker in self-checking benches and on the board link.

---
 rtl/fsm16bit_pkg.sv | 31 +++
 rtl/fsm16bit_decoder_if.sv | 29 ++
 rtl/fsm16bit_classify.sv | 47 ++++
 rtl/fsm16bit_decoder.sv | 137 +++++++++++++
 tb/tb_fsm16bit_decoder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fsm16bit_pkg.sv
// rtl/fsm16bit_pkg.sv - shared encodings and helpers for fsm16bit and its decoder
package fsm16bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } dec_state_t;

    localparam logic [15:0] SEED_DEFAULT = 16'h6453;

    // Largest add/sub amount the FSM can apply in one step (4-bit value).
    localparam logic [15:0] MAX_STEP = 16'd15;

    localparam logic MODE_ADDSUB = 1'b0;
    localparam logic MODE_ROTATE = 1'b1;

    localparam logic DIR_SUB = 1'b0;
    localparam logic DIR_ADD = 1'b1;
    localparam logic DIR_ROR = 1'b0;
    localparam logic DIR_ROL = 1'b1;

    function automatic logic [15:0] ror1(input logic [15:0] x);
        return {x[0], x[15:1]};
    endfunction

    function automatic logic [15:0] rol1(input logic [15:0] x);
        return {x[14:0], x[15]};
    endfunction

endpackage

// File: rtl/fsm16bit_decoder_if.sv
// rtl/fsm16bit_decoder_if.sv - sample input and decoded-operation output bundle
interface fsm16bit_decoder_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [15:0]      in_value;
    logic             resync;
    logic             op_valid;
    logic             op_load;
    logic             op_hold;
    logic             dec_mode;
    logic             dec_direction;
    logic [3:0]       dec_value;
    logic             op_error;
    logic [CNT_W-1:0] op_count;
    logic [1:0]       state;

    modport master (
        output in_valid, in_value, resync,
        input  op_valid, op_load, op_hold, dec_mode, dec_direction,
        input  dec_value, op_error, op_count, state
    );

    modport slave (
        input  in_valid, in_value, resync,
        output op_valid, op_load, op_hold, dec_mode, dec_direction,
        output dec_value, op_error, op_count, state
    );
endinterface

// File: rtl/fsm16bit_classify.sv
// rtl/fsm16bit_classify.sv - combinational classifier of one fsm16bit transition
module fsm16bit_classify
    import fsm16bit_pkg::*;
(
    input  logic [15:0] prev,
    input  logic [15:0] cur,
    output logic        legal,
    output logic        hold,
    output logic        mode,
    output logic        direction,
    output logic [3:0]  value
);

    logic [15:0] diff_up;
    logic [15:0] diff_dn;

    // Both differences wrap modulo 2^16, so FFFE -> 0001 is a small add.
    assign diff_up = cur - prev;
    assign diff_dn = prev - cur;

    // First match wins: hold, add, subtract, rotate right, rotate left.
    always_comb begin
        legal     = 1'b1;
        hold      = 1'b0;
        mode      = MODE_ADDSUB;
        direction = DIR_SUB;
        value     = 4'd0;
        if (cur == prev) begin
            hold = 1'b1;
        end else if (diff_up <= MAX_STEP) begin
            direction = DIR_ADD;
            value     = diff_up[3:0];
        end else if (diff_dn <= MAX_STEP) begin
            direction = DIR_SUB;
            value     = diff_dn[3:0];
        end else if (cur == ror1(prev)) begin
            mode      = MODE_ROTATE;
            direction = DIR_ROR;
        end else if (cur == rol1(prev)) begin
            mode      = MODE_ROTATE;
            direction = DIR_ROL;
        end else begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/fsm16bit_decoder.sv
// rtl/fsm16bit_decoder.sv - recovers fsm16bit control settings from its output stream
module fsm16bit_decoder
    import fsm16bit_pkg::*;
#(
    parameter logic [15:0] SEED  = SEED_DEFAULT,
    parameter int          CNT_W = 8
)
(
    input  logic                clock,
    input  logic                reset,
    fsm16bit_decoder_if.slave   bus
);

    dec_state_t       state_q;
    dec_state_t       state_d;
    logic [15:0]      prev_q;
    logic             op_valid_q;
    logic             op_load_q;
    logic             op_hold_q;
    logic             mode_q;
    logic             dir_q;
    logic [3:0]       value_q;
    logic             error_q;
    logic [CNT_W-1:0] count_q;

    logic             cls_legal;
    logic             cls_hold;
    logic             cls_mode;
    logic             cls_dir;
    logic [3:0]       cls_value;

    logic             do_load;
    logic             do_op;
    logic             do_err;

    fsm16bit_classify u_classify (
        .prev      (prev_q),
        .cur       (bus.in_value),
        .legal     (cls_legal),
        .hold      (cls_hold),
        .mode      (cls_mode),
        .direction (cls_dir),
        .value     (cls_value)
    );

    // Next state and the per-sample action; resync overrides any sample.
    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        do_op   = 1'b0;
        do_err  = 1'b0;
        if (bus.resync) begin
            state_d = ST_IDLE;
        end else if (bus.in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_value == SEED) begin
                        do_load = 1'b1;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (cls_legal) begin
                        do_op = 1'b1;
                    end else begin
                        do_err  = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Last-sample register, decoded-field registers, sticky error and op counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q     <= 16'd0;
            op_valid_q <= 1'b0;
            op_load_q  <= 1'b0;
            op_hold_q  <= 1'b0;
            mode_q     <= 1'b0;
            dir_q      <= 1'b0;
            value_q    <= 4'd0;
            error_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            op_valid_q <= do_load | do_op;
            if (do_load) begin
                prev_q    <= SEED;
                op_load_q <= 1'b1;
                op_hold_q <= 1'b0;
                mode_q    <= MODE_ADDSUB;
                dir_q     <= DIR_SUB;
                value_q   <= 4'd0;
            end
            if (do_op) begin
                prev_q    <= bus.in_value;
                op_load_q <= 1'b0;
                op_hold_q <= cls_hold;
                mode_q    <= cls_mode;
                dir_q     <= cls_dir;
                value_q   <= cls_value;
                if (!cls_hold) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
            if (do_err) begin
                error_q <= 1'b1;
            end
            if (bus.resync) begin
                error_q <= 1'b0;
                count_q <= '0;
            end
        end
    end

    assign bus.op_valid      = op_valid_q;
    assign bus.op_load       = op_load_q;
    assign bus.op_hold       = op_hold_q;
    assign bus.dec_mode      = mode_q;
    assign bus.dec_direction = dir_q;
    assign bus.dec_value     = value_q;
    assign bus.op_error      = error_q;
    assign bus.op_count      = count_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_fsm16bit_decoder.sv
// tb/tb_fsm16bit_decoder.sv - scoreboard bench for fsm16bit_decoder
module tb_fsm16bit_decoder;

    localparam logic [15:0] SEED = 16'h6453;

    typedef struct packed {
        logic       load;
        logic       hold;
        logic       mode;
        logic       dir;
        logic [3:0] value;
    } exp_t;

    logic clock;
    logic reset;

    fsm16bit_decoder_if #(.CNT_W(8)) bus ();

    fsm16bit_decoder #(.SEED(SEED), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    exp_t        exp_q[$];
    exp_t        held;
    int          m_state;
    logic [15:0] m_prev;
    logic        m_err;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference classification written straight from the transition rules.
    task automatic ref_classify(input int p, input int c, output bit ok, output exp_t e);
        int up, dn, ror, rol;
        up  = (c - p + 65536) % 65536;
        dn  = (p - c + 65536) % 65536;
        ror = (p >> 1) | ((p & 1) << 15);
        rol = ((p << 1) & 16'hFFFF) | (p >> 15);
        ok  = 1'b1;
        e   = '0;
        if (up == 0)                  e.hold = 1'b1;
        else if (up <= 15) begin      e.dir = 1'b1; e.value = 4'(up); end
        else if (dn <= 15) begin      e.dir = 1'b0; e.value = 4'(dn); end
        else if (c == ror) begin      e.mode = 1'b1; e.dir = 1'b0; end
        else if (c == rol) begin      e.mode = 1'b1; e.dir = 1'b1; end
        else                          ok = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic rs, input logic rst);
        exp_t e;
        bit   ok;
        if (rst) begin
            m_state = 0; m_prev = 16'd0; m_err = 1'b0; m_cnt = 0;
            held = '0;
            exp_q.delete();
            mon_en = 1'b1;
        end else if (rs) begin
            m_state = 0; m_err = 1'b0; m_cnt = 0;
        end else if (v) begin
            if (m_state == 0) begin
                if (d == SEED) begin
                    m_prev = SEED; m_state = 1;
                    e = '0; e.load = 1'b1;
                    exp_q.push_back(e); held = e;
                end
            end else if (m_state == 1) begin
                ref_classify(int'(m_prev), int'(d), ok, e);
                if (ok) begin
                    exp_q.push_back(e); held = e;
                    m_prev = d;
                    if (!e.hold) m_cnt = (m_cnt + 1) % 256;
                end else begin
                    m_err = 1'b1; m_state = 2;
                end
            end
        end
    endtask

    // Drive one cycle on the falling edge, then advance the model past the rising edge.
    task automatic step(input logic v, input logic [15:0] d, input logic rs, input logic rst);
        @(negedge clock);
        bus.in_valid = v;
        bus.in_value = d;
        bus.resync   = rs;
        reset        = rst;
        @(posedge clock);
        #1;
        model_step(v, d, rs, rst);
    endtask

    task automatic send(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    // Legal add/sub walk toward a target value, taking the shorter way round.
    task automatic walk_to(input logic [15:0] target);
        int diff, k;
        for (int g = 0; g < 5000 && m_prev != target && m_state == 1; g++) begin
            diff = (int'(target) - int'(m_prev) + 65536) % 65536;
            if (diff <= 32768) begin
                k = (diff < 15) ? diff : 15;
                send(16'(int'(m_prev) + k));
            end else begin
                k = ((65536 - diff) < 15) ? (65536 - diff) : 15;
                send(16'(int'(m_prev) - k));
            end
        end
        chk("walk_reached", {16'd0, m_prev}, {16'd0, target});
    endtask

    // Monitor: pops an expectation whenever one is due and checks all outputs.
    exp_t mon_e;
    always @(negedge clock) begin
        if (mon_en) begin
            chk("op_valid", {31'd0, bus.op_valid}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) mon_e = exp_q.pop_front();
            else                  mon_e = held;
            chk("op_load",   {31'd0, bus.op_load},       {31'd0, mon_e.load});
            chk("op_hold",   {31'd0, bus.op_hold},       {31'd0, mon_e.hold});
            chk("dec_mode",  {31'd0, bus.dec_mode},      {31'd0, mon_e.mode});
            chk("dec_dir",   {31'd0, bus.dec_direction}, {31'd0, mon_e.dir});
            chk("dec_value", {28'd0, bus.dec_value},     {28'd0, mon_e.value});
            chk("state",     {30'd0, bus.state},         32'(m_state));
            chk("op_error",  {31'd0, bus.op_error},      {31'd0, m_err});
            chk("op_count",  {24'd0, bus.op_count},      32'(m_cnt));
        end
    end

    initial begin
        int          r;
        int          k;
        logic [15:0] nv;
        bus.in_valid = 1'b0;
        bus.in_value = 16'd0;
        bus.resync   = 1'b0;
        reset        = 1'b1;

        // Reset, then sync through leading zeros.
        step(1'b0, 16'd0, 1'b0, 1'b1);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        step(1'b0, 16'd0, 1'b0, 1'b0);
        send(16'h0000);
        send(16'h0000);
        send(SEED);

        // Add/sub stream, idle gap, rotates and hold.
        send(16'h6450);
        send(16'h6453);
        step(1'b0, 16'h1111, 1'b0, 1'b0);
        send(16'h6458);
        send(16'h6453);
        send(16'hB229);
        send(16'h6453);
        send(16'h6453);

        // Illegal jump, ignored samples in ERROR, resync back to IDLE.
        send(16'h1234);
        send(16'h6450);
        send(SEED);
        step(1'b1, SEED, 1'b1, 1'b0);
        step(1'b1, SEED, 1'b1, 1'b0);

        // Wrap-around add and add-over-rotate priority, then ror-over-rol.
        send(SEED);
        walk_to(16'hFFFE);
        send(16'h0001);
        send(16'h0002);
        walk_to(16'h5555);
        send(16'hAAAA);

        // Reset on the same edge as a valid sample.
        step(1'b0, 16'd0, 1'b1, 1'b0);
        send(SEED);
        step(1'b1, 16'h6450, 1'b0, 1'b1);
        step(1'b1, 16'h6450, 1'b0, 1'b0);

        // Randomised traffic around a tracked stream.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 39);
            k = $urandom_range(1, 15);
            if (r == 0) begin
                step(1'b1, 16'($urandom), 1'b1, 1'b0);
            end else if (r == 1) begin
                step(1'b1, 16'($urandom), 1'b0, 1'b1);
            end else if (r < 4) begin
                step(1'b0, 16'($urandom), 1'b0, 1'b0);
            end else if (m_state == 2) begin
                step(1'b1, 16'($urandom), (r < 12) ? 1'b1 : 1'b0, 1'b0);
            end else if (m_state == 0) begin
                send((r < 20) ? SEED : 16'($urandom));
            end else begin
                if (r < 14)      nv = 16'(int'(m_prev) + k);
                else if (r < 24) nv = 16'(int'(m_prev) - k);
                else if (r < 29) nv = {m_prev[0], m_prev[15:1]};
                else if (r < 34) nv = {m_prev[14:0], m_prev[15]};
                else if (r < 38) nv = m_prev;
                else             nv = 16'($urandom);
                send(nv);
            end
        end

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
